reg_wb_sched: RTL and testbench

- Write-port scheduler and scoreboard for the 32x32 register file (two combinational read ports, one synchronous write port, x0 hard-wired to zero).
- Tracks destination registers with writes still outstanding and stalls issue on read-after-write and write-after-write hazards.
- Round-robin arbitrates N_REQ writeback requesters (ALU, LSU) onto the single write port.

---
 rtl/reg_sched_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/reg_wb_sched.sv | 146 ++++++++++++++
 tb/tb_reg_wb_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_sched_pkg.sv
// reg_sched_pkg: shared constants and types for the register-file
// writeback scheduler. REG_AW / REG_DW match the default
// ADDRESS_WIDTH / D_WIDTH parameters of reg_wb_sched.
package reg_sched_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int REG_ZERO = 0;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LSU  = 1;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // One writeback requester's view of the write port.
  typedef struct packed {
    logic              valid;
    reg_addr_t         addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter. The grant is combinational; the
// last-grant pointer is registered. Searching starts at last+1, so the
// most recent winner has the lowest priority next cycle. Reset points
// last at N_REQ-1 so requester 0 wins first.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt
);

  localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [LW-1:0] r_last;
  logic [LW-1:0] w_idx;
  logic [LW-1:0] w_cand;
  logic          w_any;

  // First requesting index after the last winner, wrapping modulo N_REQ.
  always_comb begin
    o_gnt  = '0;
    w_idx  = r_last;
    w_cand = r_last;
    w_any  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = LW'((int'(r_last) + k) % N_REQ);
      if (!w_any && i_req[w_cand]) begin
        w_any         = 1'b1;
        w_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

  // Remember the winner so it drops to lowest priority.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      r_last <= LW'(N_REQ - 1);
    else if (w_any) r_last <= w_idx;
  end

endmodule

// File: rtl/reg_wb_sched.sv
// reg_wb_sched: scoreboard plus single write-port scheduler for the
// 32x32 register file. Stalls issue on RAW/WAW against registers with
// writes outstanding and round-robins writeback requesters onto the
// registered rf_* write port.
// Optional: define REG_SCB_CHECK_EN to add the sticky 'err' output,
// which flags a writeback to a nonzero register that was not pending.
module reg_wb_sched
  import reg_sched_pkg::*;
#(
  parameter int D_WIDTH       = REG_DW,
  parameter int ADDRESS_WIDTH = REG_AW,
  parameter int N_REQ         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_valid,
  input  logic [ADDRESS_WIDTH-1:0]   iss_rd,
  input  logic                       iss_has_rd,
  input  logic [ADDRESS_WIDTH-1:0]   iss_rs1,
  input  logic [ADDRESS_WIDTH-1:0]   iss_rs2,
  output logic                       iss_ready,
  input  logic [N_REQ-1:0]           wb_valid,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [N_REQ*D_WIDTH-1:0]   wb_data,
  output logic [N_REQ-1:0]           wb_ready,
  output logic                       rf_wr_en,
  output logic [ADDRESS_WIDTH-1:0]   rf_wr_addr,
  output logic [D_WIDTH-1:0]         rf_din,
`ifdef REG_SCB_CHECK_EN
  output logic                       err,
`endif
  output logic [2**ADDRESS_WIDTH-1:0] busy
);

  localparam int NREG = 2**ADDRESS_WIDTH;

  logic [NREG-1:0]          r_busy;
  logic [NREG-1:0]          w_busy_nxt;
  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [D_WIDTH-1:0]       r_din;

  wb_req_t                  w_req [N_REQ];
  logic [N_REQ-1:0]         w_req_vld;
  logic [N_REQ-1:0]         w_gnt;
  logic                     w_gnt_any;
  logic [ADDRESS_WIDTH-1:0] w_gaddr;
  logic [D_WIDTH-1:0]       w_gdata;
  logic                     w_fire;
  logic                     w_set;

  // x0 never counts as pending, whatever the bitmap says.
  function automatic logic pend(input logic [ADDRESS_WIDTH-1:0] r,
                                input logic [NREG-1:0]          b);
    return b[r] && (r != ADDRESS_WIDTH'(REG_ZERO));
  endfunction

  // Unpack the flat requester buses into per-requester records.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i].valid = wb_valid[i];
      w_req[i].addr  = wb_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      w_req[i].data  = wb_data[i*D_WIDTH +: D_WIDTH];
      w_req_vld[i]   = w_req[i].valid;
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_clk (clk),
    .i_rst (rst),
    .i_req (w_req_vld),
    .o_gnt (w_gnt)
  );

  assign wb_ready  = w_gnt;
  assign w_gnt_any = |w_gnt;

  // Mux the granted requester's address/data (grant is one-hot).
  always_comb begin
    w_gaddr = '0;
    w_gdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_gaddr = w_req[i].addr;
        w_gdata = w_req[i].data;
      end
    end
  end

  // Stall on pending sources (RAW) and pending destination (WAW).
  assign iss_ready = !pend(iss_rs1, r_busy) && !pend(iss_rs2, r_busy) &&
                     !(iss_has_rd && pend(iss_rd, r_busy));
  assign w_fire    = iss_valid && iss_ready;
  assign w_set     = w_fire && iss_has_rd &&
                     (iss_rd != ADDRESS_WIDTH'(REG_ZERO));

  // Next bitmap: clear the register being written this cycle, then
  // apply the issue set so a coincident set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en) w_busy_nxt[r_wr_addr] = 1'b0;
    if (w_set)   w_busy_nxt[iss_rd]    = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  // Scoreboard bitmap register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // Write-port register: a grant to x0 is consumed but never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_din     <= '0;
    end else begin
      r_wr_en <= w_gnt_any && (w_gaddr != ADDRESS_WIDTH'(REG_ZERO));
      if (w_gnt_any) begin
        r_wr_addr <= w_gaddr;
        r_din     <= w_gdata;
      end
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_din     = r_din;
  assign busy       = r_busy;

`ifdef REG_SCB_CHECK_EN
  logic r_err;

  // Sticky flag: accepted writeback to a nonzero register not marked busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if (w_gnt_any && (w_gaddr != ADDRESS_WIDTH'(REG_ZERO)) &&
             !r_busy[w_gaddr])
      r_err <= 1'b1;
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_reg_wb_sched.sv
// Testbench for reg_wb_sched: directed scenario tasks plus a writeback
// scoreboard (expected rf writes queued at grant, checked on rf_wr_en).
module tb_reg_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_has_rd, iss_ready;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic [1:0]  wb_valid, wb_ready;
  logic [9:0]  wb_addr;
  logic [63:0] wb_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_din;
  logic [31:0] busy;
`ifdef REG_SCB_CHECK_EN
  logic        err;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int m_last = 1;
  logic [4:0]  q_addr[$];
  logic [31:0] q_data[$];

  reg_wb_sched dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_has_rd (iss_has_rd),
    .iss_rs1    (iss_rs1),
    .iss_rs2    (iss_rs2),
    .iss_ready  (iss_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_din     (rf_din),
`ifdef REG_SCB_CHECK_EN
    .err        (err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every rf write must match the oldest queued grant.
  always @(negedge clk) begin
    if (rst === 1'b0 && rf_wr_en === 1'b1) begin
      n_chk++;
      if (q_addr.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rf write addr=%0d din=%h, none expected", rf_wr_addr, rf_din);
      end else begin
        logic [4:0]  ea;
        logic [31:0] ed;
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        if (rf_wr_addr !== ea || rf_din !== ed) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%0d din=%h, want addr=%0d din=%h", rf_wr_addr, rf_din, ea, ed);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: search from m_last+1, queue the expected write.
  task automatic check_grant();
    logic [1:0] exp;
    int idx;
    exp = 2'b00;
    idx = -1;
    for (int k = 1; k <= 2; k++) begin
      int c;
      c = (m_last + k) % 2;
      if (idx < 0 && wb_valid[c]) begin
        idx    = c;
        exp[c] = 1'b1;
      end
    end
    n_chk++;
    if (wb_ready !== exp) begin
      n_fail++;
      $display("FAIL grant: wb_ready=%b want %b (valid=%b)", wb_ready, exp, wb_valid);
    end
    if (idx >= 0) begin
      logic [4:0]  a;
      logic [31:0] d;
      a = wb_addr[idx*5 +: 5];
      d = wb_data[idx*32 +: 32];
      if (a != 5'd0) begin
        q_addr.push_back(a);
        q_data.push_back(d);
      end
      m_last = idx;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iss_valid = 0; iss_has_rd = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 32'h0 || rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_din !== 32'h0 || wb_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset: busy=%h en=%b addr=%0d din=%h wb_ready=%b, want all 0", busy, rf_wr_en, rf_wr_addr, rf_din, wb_ready);
    end
    step(); rst = 1'b0; m_last = 1;
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: iss_ready=%b want 1", iss_ready); end
  endtask

  task automatic test_issue();
    step(); iss_valid = 1; iss_has_rd = 1; iss_rd = 5; iss_rs1 = 1; iss_rs2 = 2;
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready: iss_ready=%b want 1", iss_ready); end
    step(); iss_valid = 0;
    @(negedge clk);
    n_chk++;
    if (busy !== 32'h0000_0020) begin n_fail++; $display("FAIL issue_busy: busy=%h want 00000020", busy); end
  endtask

  task automatic test_raw();
    step(); iss_valid = 1; iss_has_rd = 0; iss_rd = 0; iss_rs1 = 5; iss_rs2 = 0;
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: iss_ready=%b want 0", iss_ready); end
    step(); wb_valid = 2'b10; wb_addr[9:5] = 5; wb_data[63:32] = 32'hDEADBEEF;
    @(negedge clk);
    check_grant();
    step(); wb_valid = 0;
    @(negedge clk);
    n_chk++;
    if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_din !== 32'hDEADBEEF || busy[5] !== 1'b1 || iss_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL raw_t1: en=%b addr=%0d din=%h busy5=%b ready=%b, want 1 5 deadbeef 1 0", rf_wr_en, rf_wr_addr, rf_din, busy[5], iss_ready);
    end
    step();
    @(negedge clk);
    n_chk++;
    if (busy !== 32'h0 || iss_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_t2: busy=%h ready=%b, want 0 1", busy, iss_ready);
    end
    step(); iss_valid = 0; iss_rs1 = 0;
  endtask

  task automatic test_waw_x0();
    iss_valid = 1; iss_has_rd = 1; iss_rd = 7; iss_rs1 = 0; iss_rs2 = 0;
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL waw_first: iss_ready=%b want 1", iss_ready); end
    step();
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b0 || busy !== 32'h80) begin n_fail++; $display("FAIL waw_stall: ready=%b busy=%h, want 0 00000080", iss_ready, busy); end
    step(); wb_valid = 2'b01; wb_addr[4:0] = 7; wb_data[31:0] = 32'h7777_0001;
    @(negedge clk);
    check_grant();
    step(); wb_valid = 0;
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL waw_t1: iss_ready=%b want 0", iss_ready); end
    step();
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL waw_t2: iss_ready=%b want 1", iss_ready); end
    step(); iss_valid = 0;
    @(negedge clk);
    n_chk++;
    if (busy !== 32'h80) begin n_fail++; $display("FAIL waw_reissue: busy=%h want 00000080", busy); end
    step(); wb_valid = 2'b01; wb_addr[4:0] = 7; wb_data[31:0] = 32'h7777_0002;
    @(negedge clk);
    check_grant();
    step(); wb_valid = 0;
    step();
    @(negedge clk);
    n_chk++;
    if (busy !== 32'h0) begin n_fail++; $display("FAIL waw_clear: busy=%h want 0", busy); end
    // issue with rd = x0 must not mark anything busy
    step(); iss_valid = 1; iss_has_rd = 1; iss_rd = 0;
    @(negedge clk);
    n_chk++;
    if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL x0_issue: iss_ready=%b want 1", iss_ready); end
    step(); iss_valid = 0;
    @(negedge clk);
    n_chk++;
    if (busy !== 32'h0) begin n_fail++; $display("FAIL x0_busy: busy=%h want 0", busy); end
    // writeback to x0 is granted but produces no rf write
    step(); wb_valid = 2'b10; wb_addr[9:5] = 0; wb_data[63:32] = 32'h1234;
    @(negedge clk);
    check_grant();
    step(); wb_valid = 0;
    @(negedge clk);
    n_chk++;
    if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL x0_wb: rf_wr_en=%b want 0", rf_wr_en); end
  endtask

  task automatic test_arbitration();
    logic [1:0] seq [4];
    int n0, n1;
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      wb_valid = 2'b11;
      wb_addr  = {5'(20 + n1), 5'(10 + n0)};
      wb_data  = {32'hB000_0000 + 32'(n1), 32'hA000_0000 + 32'(n0)};
      @(negedge clk);
      check_grant();
      n_chk++;
      if (wb_ready !== seq[c]) begin n_fail++; $display("FAIL arb_both[%0d]: wb_ready=%b want %b", c, wb_ready, seq[c]); end
      if (wb_ready[0]) n0++;
      if (wb_ready[1]) n1++;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      wb_valid = 2'b10;
      wb_addr[9:5] = 5'(25 + c);
      wb_data[63:32] = 32'hC000_0000 + 32'(c);
      @(negedge clk);
      check_grant();
      n_chk++;
      if (wb_ready !== 2'b10) begin n_fail++; $display("FAIL arb_single[%0d]: wb_ready=%b want 10", c, wb_ready); end
    end
    step(); wb_valid = 0;
    step();
    @(negedge clk);
    n_chk++;
    if (q_addr.size() != 0) begin n_fail++; $display("FAIL arb_drain: %0d writes outstanding, want 0", q_addr.size()); end
  endtask

  task automatic test_async_reset();
    step(); iss_valid = 1; iss_has_rd = 1; iss_rd = 3;
    @(negedge clk);
    step(); iss_valid = 0; wb_valid = 2'b01; wb_addr[4:0] = 4; wb_data[31:0] = 32'hA5A5_A5A5;
    @(negedge clk);
    check_grant();
    n_chk++;
    if (busy !== 32'h08) begin n_fail++; $display("FAIL ares_pre: busy=%h want 00000008", busy); end
    step(); wb_valid = 0;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 32'h0 || rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_din !== 32'h0) begin
      n_fail++;
      $display("FAIL ares_now: busy=%h en=%b addr=%0d din=%h, want all 0", busy, rf_wr_en, rf_wr_addr, rf_din);
    end
    q_addr.delete(); q_data.delete(); m_last = 1;
    step();
    step(); rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL ares_after0: rf_wr_en=%b want 0", rf_wr_en); end
    step();
    @(negedge clk);
    n_chk++;
    if (rf_wr_en !== 1'b0 || busy !== 32'h0) begin n_fail++; $display("FAIL ares_after1: en=%b busy=%h, want 0 0", rf_wr_en, busy); end
  endtask

`ifdef REG_SCB_CHECK_EN
  task automatic test_err();
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_init: err=%b want 0", err); end
    step(); wb_valid = 2'b10; wb_addr[9:5] = 9; wb_data[63:32] = 32'h0909_0909;
    @(negedge clk);
    check_grant();
    step(); wb_valid = 0;
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: err=%b want 1", err); end
    repeat (3) step();
    @(negedge clk);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: err=%b want 1", err); end
    step(); rst = 1'b1;
    #1;
    n_chk++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: err=%b want 0", err); end
    m_last = 1;
    step(); rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_issue();
    test_raw();
    test_waw_x0();
    test_arbitration();
    test_async_reset();
`ifdef REG_SCB_CHECK_EN
    test_err();
`endif
    step();
    @(negedge clk);
    n_chk++;
    if (q_addr.size() != 0) begin n_fail++; $display("FAIL final_drain: %0d writes outstanding, want 0", q_addr.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
